// File: rtl/core0_sync_mem.sv
// Parametrised synchronous memory for the core0 program/main buses: byte-lane writes,
// pipelined reads with configurable latency, selectable read-during-write, optional clear.
module core0_sync_mem #(
    parameter int WIDTH          = 32,
    parameter int ADDR_WIDTH     = 2,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    input  logic                    read_en,
    output logic [WIDTH-1:0]        read_value,
    output logic                    read_valid,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [WIDTH-1:0]        write_value,
    input  logic [WIDTH/8-1:0]      write_be,
    input  logic                    we,
    output logic                    busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LANES = WIDTH / 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Expand byte-lane enables into a per-bit mask.
    function automatic logic [WIDTH-1:0] lane_mask(input logic [LANES-1:0] be);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   clear_addr_r;
    logic                    busy_r;
    logic [WIDTH-1:0]        mem_r [DEPTH];
    logic [WIDTH-1:0]        read_value_r;
    logic                    read_valid_r;

    logic                    run_s;
    logic                    wr_fire_s;
    logic                    rd_fire_s;
    logic [WIDTH-1:0]        wr_mask_s;
    logic [WIDTH-1:0]        rd_word_s;
    logic                    out_v_s;
    logic [WIDTH-1:0]        out_d_s;

    assign run_s     = (state_r == ST_RUN);
    assign wr_fire_s = we & run_s;
    assign rd_fire_s = read_en & run_s;
    assign wr_mask_s = lane_mask(write_be);

    // Sampled read word, optionally merged with a same-edge write to the same address.
    always_comb begin
        rd_word_s = mem_r[read_addr];
        if ((RDW_MODE != 0) && wr_fire_s && (write_addr == read_addr)) begin
            rd_word_s = (mem_r[read_addr] & ~wr_mask_s) | (write_value & wr_mask_s);
        end else begin
            rd_word_s = mem_r[read_addr];
        end
    end

    // Latency 1 registers straight into the output; longer latencies add READ_LATENCY-1 stages.
    generate
        if (READ_LATENCY > 1) begin : g_pipe
            logic [READ_LATENCY-2:0] pv_r;
            logic [WIDTH-1:0]        pd_r [0:READ_LATENCY-2];

            // Read pipeline shift register; valid bits are dropped on reset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pv_r <= '0;
                    for (int i = 0; i < READ_LATENCY - 1; i++) begin
                        pd_r[i] <= '0;
                    end
                end else begin
                    pv_r[0] <= rd_fire_s;
                    pd_r[0] <= rd_word_s;
                    for (int i = 1; i < READ_LATENCY - 1; i++) begin
                        pv_r[i] <= pv_r[i-1];
                        pd_r[i] <= pd_r[i-1];
                    end
                end
            end

            assign out_v_s = pv_r[READ_LATENCY-2];
            assign out_d_s = pd_r[READ_LATENCY-2];
        end else begin : g_direct
            assign out_v_s = rd_fire_s;
            assign out_d_s = rd_word_s;
        end
    endgenerate

    // Control FSM, memory array updates and registered read outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clear_addr_r <= '0;
            busy_r       <= (CLEAR_ON_RESET != 0);
            read_value_r <= '0;
            read_valid_r <= 1'b0;
        end else begin
            read_valid_r <= out_v_s;
            if (out_v_s) begin
                read_value_r <= out_d_s;
            end
            case (state_r)
                ST_CLEAR: begin
                    mem_r[clear_addr_r] <= '0;
                    clear_addr_r        <= clear_addr_r + ADDR_WIDTH'(1'b1);
                    // DEPTH is a power of two, so the last address is all ones.
                    if (&clear_addr_r) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (wr_fire_s) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (write_be[i]) begin
                                mem_r[write_addr][8*i +: 8] <= write_value[8*i +: 8];
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign read_value = read_value_r;
    assign read_valid = read_valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_core0_sync_mem.sv
// Directed bench for core0_sync_mem: five instances cover latency, read-during-write,
// clear-on-reset and reset-during-read behaviour from shared stimulus.
module tb_core0_sync_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_c, rst_d;
    logic [1:0]  read_addr, write_addr;
    logic        read_en, we;
    logic [31:0] write_value;
    logic [3:0]  write_be;

    logic [4:0][31:0] rv;
    logic [4:0]       vl;
    logic [4:0]       bz;

    int errors = 0;
    int checks = 0;

    // u0: latency 1 old-data, u1: latency 3, u2: latency 1 new-data, u3: clear on reset, u4: latency 4
    core0_sync_mem #(.WIDTH(32), .ADDR_WIDTH(2), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u0 (
        .clk(clk), .reset(rst_a), .read_addr(read_addr), .read_en(read_en), .read_value(rv[0]),
        .read_valid(vl[0]), .write_addr(write_addr), .write_value(write_value), .write_be(write_be),
        .we(we), .busy(bz[0]));
    core0_sync_mem #(.WIDTH(32), .ADDR_WIDTH(2), .READ_LATENCY(3), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u1 (
        .clk(clk), .reset(rst_a), .read_addr(read_addr), .read_en(read_en), .read_value(rv[1]),
        .read_valid(vl[1]), .write_addr(write_addr), .write_value(write_value), .write_be(write_be),
        .we(we), .busy(bz[1]));
    core0_sync_mem #(.WIDTH(32), .ADDR_WIDTH(2), .READ_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(0)) u2 (
        .clk(clk), .reset(rst_a), .read_addr(read_addr), .read_en(read_en), .read_value(rv[2]),
        .read_valid(vl[2]), .write_addr(write_addr), .write_value(write_value), .write_be(write_be),
        .we(we), .busy(bz[2]));
    core0_sync_mem #(.WIDTH(32), .ADDR_WIDTH(2), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u3 (
        .clk(clk), .reset(rst_c), .read_addr(read_addr), .read_en(read_en), .read_value(rv[3]),
        .read_valid(vl[3]), .write_addr(write_addr), .write_value(write_value), .write_be(write_be),
        .we(we), .busy(bz[3]));
    core0_sync_mem #(.WIDTH(32), .ADDR_WIDTH(2), .READ_LATENCY(4), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u4 (
        .clk(clk), .reset(rst_d), .read_addr(read_addr), .read_en(read_en), .read_value(rv[4]),
        .read_valid(vl[4]), .write_addr(write_addr), .write_value(write_value), .write_be(write_be),
        .we(we), .busy(bz[4]));

    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] wval;
        logic [3:0]  be;
        logic        re;
        logic [1:0]  raddr;
        logic        ev;
        logic [31:0] ed0;
        logic [31:0] ed2;
    } vec_t;

    vec_t        tbl [14];
    logic [31:0] bb_exp [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read_en  = 1'b0;
        we       = 1'b0;
        write_be = 4'h0;
    endtask

    task automatic preload_ff();
        for (int a = 0; a < 4; a++) begin
            idle();
            we          = 1'b1;
            write_addr  = 2'(a);
            write_value = 32'hFFFF_FFFF;
            write_be    = 4'hF;
            step();
        end
        idle();
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 4; a++) begin
            idle();
            read_en   = 1'b1;
            read_addr = 2'(a);
            step();
            chk({tag, "_valid"}, 32'(vl[3]), 32'h1);
            chk({tag, "_value"}, rv[3], 32'h0);
        end
        idle();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 32'h0000_0000, 4'hF, 1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[1]  = '{1'b0, 2'd0, 32'h0000_0000, 4'h0, 1'b1, 2'd0, 1'b1, 32'h0000_0000, 32'h0000_0000};
        tbl[2]  = '{1'b1, 2'd1, 32'h0000_0001, 4'hF, 1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[3]  = '{1'b1, 2'd2, 32'hAABB_CCDD, 4'hF, 1'b1, 2'd1, 1'b1, 32'h0000_0001, 32'h0000_0001};
        tbl[4]  = '{1'b1, 2'd3, 32'h55AA_55AA, 4'hF, 1'b1, 2'd2, 1'b1, 32'hAABB_CCDD, 32'hAABB_CCDD};
        tbl[5]  = '{1'b1, 2'd2, 32'h1122_3344, 4'h5, 1'b1, 2'd2, 1'b1, 32'hAABB_CCDD, 32'hAA22_CC44};
        tbl[6]  = '{1'b0, 2'd0, 32'h0000_0000, 4'h0, 1'b1, 2'd2, 1'b1, 32'hAA22_CC44, 32'hAA22_CC44};
        tbl[7]  = '{1'b1, 2'd3, 32'h1234_5678, 4'h0, 1'b1, 2'd3, 1'b1, 32'h55AA_55AA, 32'h55AA_55AA};
        tbl[8]  = '{1'b0, 2'd0, 32'h0000_0000, 4'h0, 1'b1, 2'd3, 1'b1, 32'h55AA_55AA, 32'h55AA_55AA};
        tbl[9]  = '{1'b1, 2'd0, 32'hDEAD_BEEF, 4'h8, 1'b1, 2'd1, 1'b1, 32'h0000_0001, 32'h0000_0001};
        tbl[10] = '{1'b0, 2'd0, 32'h0000_0000, 4'h0, 1'b1, 2'd0, 1'b1, 32'hDE00_0000, 32'hDE00_0000};
        tbl[11] = '{1'b0, 2'd0, 32'h0000_0000, 4'h0, 1'b0, 2'd0, 1'b0, 32'hDE00_0000, 32'hDE00_0000};
        tbl[12] = '{1'b1, 2'd1, 32'hCAFE_F00D, 4'hF, 1'b1, 2'd0, 1'b1, 32'hDE00_0000, 32'hDE00_0000};
        tbl[13] = '{1'b0, 2'd0, 32'h0000_0000, 4'h0, 1'b1, 2'd1, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D};
        bb_exp = '{32'hDE00_0000, 32'h0000_0001, 32'hAA22_CC44, 32'h55AA_55AA};

        rst_a = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        idle();
        read_addr = 2'd0; write_addr = 2'd0; write_value = 32'h0;
        step();
        step();
        chk("rst_u0_value", rv[0], 32'h0);
        chk("rst_u0_valid", 32'(vl[0]), 32'h0);
        chk("rst_u0_busy", 32'(bz[0]), 32'h0);
        chk("rst_u3_busy", 32'(bz[3]), 32'h1);
        chk("rst_u4_valid", 32'(vl[4]), 32'h0);
        rst_a = 1'b0; rst_c = 1'b0; rst_d = 1'b0;

        // Latency-1 write/read/byte-lane/read-during-write table
        for (int i = 0; i < 14; i++) begin
            we          = tbl[i].we;
            write_addr  = tbl[i].waddr;
            write_value = tbl[i].wval;
            write_be    = tbl[i].be;
            read_en     = tbl[i].re;
            read_addr   = tbl[i].raddr;
            step();
            chk($sformatf("tbl%0d_u0_valid", i), 32'(vl[0]), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_u0_value", i), rv[0], tbl[i].ed0);
            chk($sformatf("tbl%0d_u2_value", i), rv[2], tbl[i].ed2);
        end
        idle();
        step(); step(); step();

        // Latency 3: single read then four back-to-back reads
        we = 1'b1; write_addr = 2'd1; write_value = 32'h1; write_be = 4'hF;
        step();
        idle();
        read_en = 1'b1; read_addr = 2'd1;
        step();
        chk("l3_k0_valid", 32'(vl[1]), 32'h0);
        idle();
        step();
        chk("l3_k1_valid", 32'(vl[1]), 32'h0);
        step();
        chk("l3_k2_valid", 32'(vl[1]), 32'h1);
        chk("l3_k2_value", rv[1], 32'h1);
        step();
        chk("l3_k3_valid", 32'(vl[1]), 32'h0);
        chk("l3_k3_hold", rv[1], 32'h1);
        for (int c = 0; c < 7; c++) begin
            idle();
            if (c < 4) begin
                read_en   = 1'b1;
                read_addr = 2'(c);
            end
            step();
            chk($sformatf("l3_bb%0d_valid", c), 32'(vl[1]), (c >= 2 && c <= 5) ? 32'h1 : 32'h0);
            if (c >= 2 && c <= 5) chk($sformatf("l3_bb%0d_value", c), rv[1], bb_exp[c-2]);
        end

        // Latency 4: one read delivered, then reset with three reads in flight
        idle();
        read_en = 1'b1; read_addr = 2'd2;
        step();
        idle();
        step();
        step();
        chk("l4_e2_valid", 32'(vl[4]), 32'h0);
        step();
        chk("l4_e3_valid", 32'(vl[4]), 32'h1);
        chk("l4_e3_value", rv[4], 32'hAA22_CC44);
        for (int a = 1; a < 4; a++) begin
            read_en = 1'b1; read_addr = 2'(a);
            step();
        end
        idle();
        rst_d = 1'b1;
        #1;
        chk("l4_rst_valid", 32'(vl[4]), 32'h0);
        chk("l4_rst_value", rv[4], 32'h0);
        step();
        rst_d = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("l4_post%0d_valid", c), 32'(vl[4]), 32'h0);
        end
        chk("l4_post_value", rv[4], 32'h0);

        // Clear on reset: requests during busy are ignored, words read zero afterwards
        preload_ff();
        read_en = 1'b1; read_addr = 2'd3;
        step();
        chk("clr_preload", rv[3], 32'hFFFF_FFFF);
        idle();
        rst_c = 1'b1;
        #1;
        chk("clr_rst_busy", 32'(bz[3]), 32'h1);
        step();
        chk("clr_rst_busy_held", 32'(bz[3]), 32'h1);
        rst_c = 1'b0;
        for (int c = 0; c < 4; c++) begin
            idle();
            if (c == 1) begin
                read_en = 1'b1; read_addr = 2'd3;
            end else if (c == 2) begin
                we = 1'b1; write_addr = 2'd0; write_value = 32'h1234_5678; write_be = 4'hF;
                read_en = 1'b1; read_addr = 2'd0;
            end
            step();
            chk($sformatf("clr_e%0d_busy", c), 32'(bz[3]), (c < 3) ? 32'h1 : 32'h0);
            chk($sformatf("clr_e%0d_valid", c), 32'(vl[3]), 32'h0);
        end
        idle();
        read_all_zero("clr_read");

        // Reset re-asserted after two clear edges restarts the full sequence
        preload_ff();
        rst_c = 1'b1;
        step();
        rst_c = 1'b0;
        step();
        step();
        chk("rst2_mid_busy", 32'(bz[3]), 32'h1);
        rst_c = 1'b1;
        #1;
        chk("rst2_reassert_busy", 32'(bz[3]), 32'h1);
        step();
        rst_c = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("rst2_e%0d_busy", c), 32'(bz[3]), (c < 3) ? 32'h1 : 32'h0);
        end
        read_all_zero("rst2_read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core0_sync_mem.md
Name: core0_sync_mem

Overview:
Parametrised synchronous memory for the core0 program and main memory buses. It replaces the ad-hoc behavioural arrays in core0 benches with one reusable block. It adds configurable read latency, byte-lane write enables, a selectable read-during-write policy, a read-valid strobe, and an optional hardware clear sequence after reset. One instance serves the main memory bus (WIDTH=32) and another the program memory bus (WIDTH=8).

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8
ADDR_WIDTH, 2, address width; DEPTH = 1 << ADDR_WIDTH words
READ_LATENCY, 1, edges from read sample to data valid; legal range 1..4
RDW_MODE, 0, same-edge read/write to the same address: 0 = old data, 1 = new (merged) data
CLEAR_ON_RESET, 0, 1 = zero all words after reset via the clear sequence; 0 = contents persist across reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
read_addr  input  ADDR_WIDTH  read address, sampled when read_en=1
read_en  input  1  read request
read_value  output  WIDTH  read data
read_valid  output  1  one-cycle strobe: read_value carries data for a request
write_addr  input  ADDR_WIDTH  write address
write_value  input  WIDTH  write data
write_be  input  WIDTH/8  byte-lane enables; bit i covers bits [8i+7:8i]
we  input  1  write request
busy  output  1  clear sequence in progress; requests are ignored

Behaviour:
- Reset (asynchronous, active-high):
  - read_value=0 and read_valid=0.
  - All read pipeline valid bits are cleared.
  - Clear FSM goes to CLEAR with clear_addr=0 if CLEAR_ON_RESET=1, otherwise to RUN.
  - busy=1 while reset is held if CLEAR_ON_RESET=1, else busy=0.
  - The memory array is never asynchronously cleared.
- FSM states: CLEAR and RUN. CLEAR_ON_RESET=0 stays in RUN permanently.
- CLEAR state:
  - Each edge with reset low writes 0 to clear_addr, then increments clear_addr.
  - After the edge that writes DEPTH-1, go to RUN; busy falls on that edge.
  - CLEAR lasts exactly DEPTH edges.
- While busy=1: read_en and we are ignored, and no read_valid pulse results.
- Reset asserted mid-CLEAR: the sequence restarts from address 0 after deassert.
- Write (RUN, we=1):
  - On the edge, mem[write_addr] lanes with write_be=1 take write_value; other lanes are unchanged.
  - write_be=0 with we=1 is a no-op.
- Read (RUN, read_en=1):
  - Address and the memory contents are captured at edge k.
  - read_value and read_valid update at edge k+READ_LATENCY-1. READ_LATENCY=1 means data is registered on the sampling edge itself.
  - The pipeline is fully pipelined: one new read per cycle, no stalls.
  - read_valid is high for exactly one cycle per request.
  - read_value holds its last value when no result is delivered.
- Read-during-write, same edge and same address:
  - RDW_MODE=0: returns pre-write data.
  - RDW_MODE=1: returns (old & ~lanes) | (write_value & lanes).
  - Writes landing after the sample edge are never forwarded into in-flight reads.
- Different addresses on the same edge are independent.
- Addresses wrap naturally at DEPTH; there is no out-of-range condition.
- Reset mid-read: in-flight reads are dropped and no read_valid follows.

Test Plan:
- Defaults, reset pulse, we=1 addr=0 value=0 be=4'hF, then read addr 0 -> read_valid one edge after request, read_value=0 (mirrors the existing write test).
- Write 32'h1 to addr 1, next cycle read_en addr 1, READ_LATENCY=3 -> read_valid and read_value=1 two edges after the sampling edge; back-to-back reads of addr 0..3 -> four consecutive valid strobes in order.
- mem[2]=32'hAABBCCDD, write 32'h11223344 be=4'b0101 to addr 2 with a same-edge read of addr 2 -> RDW_MODE=0 returns AABBCCDD then mem=AA22CC44; RDW_MODE=1 returns AA22CC44.
- CLEAR_ON_RESET=1, memory preloaded with 32'hFFFFFFFF, reset released -> busy=1 for 4 edges; a read/write issued during busy is ignored; afterwards all four words read 0.
- CLEAR_ON_RESET=1, reset re-asserted after 2 clear edges -> busy stays 1; clear restarts at 0 and takes 4 full edges after release.
- READ_LATENCY=4, reset asserted with 3 reads in flight -> read_valid never pulses and read_value=0 after reset.
